// File: rtl/ex_muldiv_unit_if.sv
// Handshake and operand/result bundle between the ID/EX register and the
// iterative RV32M multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, funct3, rs1_data, rs2_data, rd_in,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data, rd_in,
    output stall, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with the pipeline stalled until the registered result.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  ex_muldiv_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN,
    S_DONE
  } state_t;

  state_t            state, next_state;
  logic [CW-1:0]     counter;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op_f3;
  logic [4:0]        rd_q;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_result;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fin_result;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // Operand signedness: MULH, MULHSU take A signed; MULH, DIV, REM take both signed.
  assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3[2] && !bus.funct3[0]);
  assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3[2] && !bus.funct3[0]);
  assign a_neg    = a_signed && bus.rs1_data[XLEN-1];
  assign b_neg    = b_signed && bus.rs2_data[XLEN-1];
  assign a_abs    = a_neg ? -bus.rs1_data : bus.rs1_data;
  assign b_abs    = b_neg ? -bus.rs2_data : bus.rs2_data;

  assign div_zero = bus.funct3[2] && (bus.rs2_data == '0);
  assign div_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                    (bus.rs1_data == MIN_INT) && (bus.rs2_data == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = bus.funct3[1] ? bus.rs1_data : '1;
    else if (div_ovf)
      special_result = bus.funct3[1] ? '0 : MIN_INT;
  end

  assign accept = (state == S_IDLE) && bus.start && !bus.flush;

  // Multiply: acc = {partial product high, remaining multiplier bits}, shifting right.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifting left.
  assign div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
  assign div_next  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fin_result = '0;
    if (!op_f3[2])
      fin_result = (op_f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else
      fin_result = op_f3[1] ? rem : quo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    bus.stall  = 1'b0;
    bus.done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          bus.stall  = 1'b1;
          next_state = special ? S_DONE : (bus.funct3[2] ? S_DIV : S_MUL);
        end
      end
      S_MUL, S_DIV: begin
        bus.stall = 1'b1;
        if (bus.flush)
          next_state = S_IDLE;
        else if (counter == CW'(1))
          next_state = S_FIN;
      end
      S_FIN: begin
        bus.stall  = 1'b1;
        next_state = bus.flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        bus.done   = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter  <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_f3    <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (accept) begin
      op_f3   <= bus.funct3;
      rd_q    <= bus.rd_in;
      counter <= CW'(XLEN);
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      if (bus.funct3[2]) begin
        acc  <= {{XLEN{1'b0}}, a_abs};
        opnd <= b_abs;
      end else begin
        acc  <= {{XLEN{1'b0}}, b_abs};
        opnd <= a_abs;
      end
      if (special) begin
        result_q <= special_result;
        rd_out_q <= bus.rd_in;
      end
    end else if (!bus.flush) begin
      case (state)
        S_MUL: begin
          acc     <= mul_next;
          counter <= counter - CW'(1);
        end
        S_DIV: begin
          acc     <= div_next;
          counter <= counter - CW'(1);
        end
        S_FIN: begin
          result_q <= fin_result;
          rd_out_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, random ops
// against an arithmetic reference, flush and mid-operation reset.
module tb_ex_muldiv_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] last_result;
  logic [4:0]  last_rd;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      p;
    logic [63:0] up;
    int          ia, ib;
    logic        ovf;
    ia  = int'(a);
    ib  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
      3'd1: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
      3'd2: begin p = longint'(ia) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Presents one op in the IDLE cycle and holds start high through DONE,
  // as the stalled ID/EX register would.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input string tag);
    logic [31:0] exp;
    bit          sp;
    bit          got;
    int          edges, stl;
    exp = model(f, a, b);
    sp  = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    @(negedge clk);
    check({tag, "_pre_done"}, 32'(bus.done), 32'd0);
    bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = f;
    bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
    #1;
    check({tag, "_stall_start"}, 32'(bus.stall), 32'd1);
    edges = 0; stl = 1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      edges++;
      if (bus.done) got = 1;
      else if (bus.stall) stl++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(edges), sp ? 32'd1 : 32'd34);
    check({tag, "_stall_cycles"}, 32'(stl), sp ? 32'd1 : 32'd34);
    check({tag, "_stall_in_done"}, 32'(bus.stall), 32'd0);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_rd"}, 32'(bus.rd_out), 32'(rd));
    last_result = exp;
    last_rd     = rd;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          dcount;
    checks = 0; failures = 0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    // Directed, back to back: each op enters the cycle after the previous DONE.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, "mul_7_m3");
    check("mul_7_m3_const", bus.result, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_max");
    check("mulhu_max_const", bus.result, 32'hFFFF_FFFE);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, "mulh_min");
    check("mulh_min_const", bus.result, 32'h4000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, "mulhsu_m1_2");
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd5, "div_m20_3");
    check("div_m20_3_const", bus.result, 32'hFFFF_FFFA);
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd6, "rem_m20_3");
    check("rem_m20_3_const", bus.result, 32'hFFFF_FFFE);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, "divu_100_7");
    check("divu_100_7_const", bus.result, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, "remu_100_7");
    check("remu_100_7_const", bus.result, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 5'd9, "div_by0");
    run_op(3'd6, 32'd5, 32'd0, 5'd10, "rem_by0");
    check("rem_by0_const", bus.result, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "rem_ovf");

    for (int n = 0; n < 24; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(f, a, b, 5'($urandom_range(1, 31)), $sformatf("rand%0d_f%0d", n, f));
    end

    // Flush at iteration 5 of a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd7; bus.rd_in = 5'd20;
    for (int i = 0; i < 5; i++) @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_stall_drop", 32'(bus.stall), 32'd0);
    check("flush_rd_hold", 32'(bus.rd_out), 32'(last_rd));
    check("flush_result_hold", bus.result, last_result);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("flush_no_done", 32'(dcount), 32'd0);

    // Reset at iteration 10 of a signed divide, then a fresh op.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.rs1_data = 32'hFFFF_FFEC;
    bus.rs2_data = 32'd3; bus.rd_in = 5'd21;
    for (int i = 0; i < 10; i++) @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    #1;
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    check("midrst_rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(3'd0, 32'd123456, 32'd789, 5'd22, "post_rst_mul");
    @(negedge clk);
    bus.start = 1'b0;
    check("post_rst_single_pulse", 32'(bus.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
